// File: rtl/uart_mmio_ctrl.sv
// ============================================================================
// Module   : uart_mmio_ctrl
// Purpose  : CPU register interface that buffers UART TX/RX bytes in FIFOs,
//            with status, control, sticky overflow flags and a level irq.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_mmio_ctrl #(
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [3:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  output logic        uart_tx_valid,
  output logic [7:0]  uart_tx_data,
  input  logic        uart_tx_ready,
  input  logic        uart_rx_valid,
  input  logic [7:0]  uart_rx_data,
  output logic        uart_rx_ready,
  output logic        irq
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int TX_CW = TX_AW + 1;
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int RX_CW = RX_AW + 1;

  logic [7:0]       r_tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] r_tx_wptr, r_tx_rptr;
  logic [TX_CW-1:0] r_tx_count;
  logic [7:0]       r_rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] r_rx_wptr, r_rx_rptr;
  logic [RX_CW-1:0] r_rx_count;
  logic [2:0]       r_ctrl;
  logic             r_rx_ovf, r_tx_ovf;

  logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic w_sel_data, w_sel_ctrl, w_sel_clr;
  logic w_tx_wr, w_tx_push, w_tx_pop, w_tx_ovf_set;
  logic w_rx_rd, w_rx_push, w_rx_pop, w_rx_ovf_set;
  logic w_ctrl_wr, w_clr_wr;
  logic [31:0] w_stat, w_rdata;
  logic w_unused;

  assign w_tx_full  = (r_tx_count == TX_CW'(TX_DEPTH));
  assign w_tx_empty = (r_tx_count == '0);
  assign w_rx_full  = (r_rx_count == RX_CW'(RX_DEPTH));
  assign w_rx_empty = (r_rx_count == '0);

  assign w_sel_data = (bus_addr[3:2] == 2'd0);
  assign w_sel_ctrl = (bus_addr[3:2] == 2'd2);
  assign w_sel_clr  = (bus_addr[3:2] == 2'd3);

  // Full/empty come from registered counts, so a same-cycle pop never rescues a write.
  assign w_tx_wr      = bus_req & bus_we & w_sel_data;
  assign w_tx_push    = w_tx_wr & ~w_tx_full;
  assign w_tx_ovf_set = w_tx_wr & w_tx_full;
  assign w_rx_rd      = bus_req & ~bus_we & w_sel_data;
  assign w_rx_pop     = w_rx_rd & ~w_rx_empty;
  assign w_ctrl_wr    = bus_req & bus_we & w_sel_ctrl;
  assign w_clr_wr     = bus_req & bus_we & w_sel_clr;

  assign uart_tx_valid = r_ctrl[0] & ~w_tx_empty;
  assign uart_tx_data  = r_tx_mem[r_tx_rptr];
  assign w_tx_pop      = uart_tx_valid & uart_tx_ready;

  assign uart_rx_ready = ~w_rx_full;
  assign w_rx_push     = uart_rx_valid & ~w_rx_full;
  assign w_rx_ovf_set  = uart_rx_valid & w_rx_full;

  assign w_stat = {8'd0, 8'(r_tx_count), 8'(r_rx_count), 2'b00,
                   r_tx_ovf, r_rx_ovf, w_rx_full, w_rx_empty, w_tx_empty, w_tx_full};

  assign w_unused = ^{bus_addr[1:0], bus_wdata[31:8]};

  always_comb begin
    w_rdata = '0;
    case (bus_addr[3:2])
      2'd0:    w_rdata = w_rx_empty ? 32'd0 : {24'd0, r_rx_mem[r_rx_rptr]};
      2'd1:    w_rdata = w_stat;
      2'd2:    w_rdata = {29'd0, r_ctrl};
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < TX_DEPTH; i++) r_tx_mem[i] <= '0;
      r_tx_wptr  <= '0;
      r_tx_rptr  <= '0;
      r_tx_count <= '0;
    end else begin
      if (w_tx_push) begin
        r_tx_mem[r_tx_wptr] <= bus_wdata[7:0];
        r_tx_wptr           <= r_tx_wptr + 1'b1;
      end
      if (w_tx_pop) r_tx_rptr <= r_tx_rptr + 1'b1;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_count <= r_tx_count + 1'b1;
        2'b01:   r_tx_count <= r_tx_count - 1'b1;
        default: r_tx_count <= r_tx_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < RX_DEPTH; i++) r_rx_mem[i] <= '0;
      r_rx_wptr  <= '0;
      r_rx_rptr  <= '0;
      r_rx_count <= '0;
    end else begin
      if (w_rx_push) begin
        r_rx_mem[r_rx_wptr] <= uart_rx_data;
        r_rx_wptr           <= r_rx_wptr + 1'b1;
      end
      if (w_rx_pop) r_rx_rptr <= r_rx_rptr + 1'b1;
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_count <= r_rx_count + 1'b1;
        2'b01:   r_rx_count <= r_rx_count - 1'b1;
        default: r_rx_count <= r_rx_count;
      endcase
    end
  end

  // Sticky flag set wins over a same-cycle W1C clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ctrl    <= 3'b001;
      r_rx_ovf  <= 1'b0;
      r_tx_ovf  <= 1'b0;
      bus_ack   <= 1'b0;
      bus_rdata <= '0;
      irq       <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_ctrl <= bus_wdata[2:0];
      r_rx_ovf  <= w_rx_ovf_set | (r_rx_ovf & ~(w_clr_wr & bus_wdata[4]));
      r_tx_ovf  <= w_tx_ovf_set | (r_tx_ovf & ~(w_clr_wr & bus_wdata[5]));
      bus_ack   <= bus_req;
      bus_rdata <= (bus_req & ~bus_we) ? w_rdata : 32'd0;
      irq       <= (r_ctrl[1] & ~w_rx_empty) | (r_ctrl[2] & w_tx_empty) | r_rx_ovf | r_tx_ovf;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_mmio_ctrl.sv
// ============================================================================
// Module   : tb_uart_mmio_ctrl
// Purpose  : Directed table-driven and sequence checks for uart_mmio_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_mmio_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        bus_req = 1'b0;
  logic        bus_we = 1'b0;
  logic [3:0]  bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        uart_tx_valid;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_ready = 1'b0;
  logic        uart_rx_valid = 1'b0;
  logic [7:0]  uart_rx_data = '0;
  logic        uart_rx_ready;
  logic        irq;

  int checks = 0;
  int errors = 0;

  uart_mmio_ctrl #(.TX_DEPTH(8), .RX_DEPTH(8)) dut (
    .clk(clk), .rstn(rstn),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .uart_tx_valid(uart_tx_valid), .uart_tx_data(uart_tx_data), .uart_tx_ready(uart_tx_ready),
    .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data), .uart_rx_ready(uart_rx_ready),
    .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_op(input logic we, input logic [3:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd);
    @(negedge clk);
    bus_req = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wd;
    @(negedge clk);
    bus_req = 1'b0; bus_we = 1'b0;
    chk("bus_ack", {31'd0, bus_ack}, 32'd1);
    rd = bus_rdata;
  endtask

  task automatic inject(input logic [7:0] b);
    @(negedge clk);
    uart_rx_valid = 1'b1; uart_rx_data = b;
    @(negedge clk);
    uart_rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // Collect n bytes from the TX side, expecting first, first+1, ...
  task automatic drain(input int n, input logic [7:0] first, input bit alt, input string name);
    int got = 0;
    for (int cyc = 0; cyc < 60 && got < n; cyc++) begin
      @(negedge clk);
      uart_tx_ready = alt ? cyc[0] : 1'b1;
      if (uart_tx_ready && uart_tx_valid) begin
        chk(name, {24'd0, uart_tx_data}, {24'd0, first + 8'(got)});
        got++;
      end
    end
    @(negedge clk);
    uart_tx_ready = 1'b0;
    chk({name, "_count"}, got, n);
    chk({name, "_valid_after"}, {31'd0, uart_tx_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;

    vecs[0]  = '{1'b0, 4'h4, 32'h0,          1'b1, 32'h0000_0006, "stat_reset"};
    vecs[1]  = '{1'b0, 4'h8, 32'h0,          1'b1, 32'h0000_0001, "ctrl_reset"};
    vecs[2]  = '{1'b0, 4'hC, 32'h0,          1'b1, 32'h0000_0000, "clr_read"};
    vecs[3]  = '{1'b0, 4'h0, 32'h0,          1'b1, 32'h0000_0000, "data_empty"};
    vecs[4]  = '{1'b1, 4'h8, 32'hFFFF_FFF8,  1'b0, 32'h0,         "ctrl_wr0"};
    vecs[5]  = '{1'b0, 4'h8, 32'h0,          1'b1, 32'h0000_0000, "ctrl_0"};
    vecs[6]  = '{1'b1, 4'h8, 32'h0000_0007,  1'b0, 32'h0,         "ctrl_wr7"};
    vecs[7]  = '{1'b0, 4'h8, 32'h0,          1'b1, 32'h0000_0007, "ctrl_7"};
    vecs[8]  = '{1'b1, 4'h8, 32'h0000_0001,  1'b0, 32'h0,         "ctrl_wr1"};
    vecs[9]  = '{1'b1, 4'h0, 32'h0000_0111,  1'b0, 32'h0,         "data_wr11"};
    vecs[10] = '{1'b0, 4'h4, 32'h0,          1'b1, 32'h0001_0004, "stat_tx1"};
    vecs[11] = '{1'b1, 4'h0, 32'h0000_AB22,  1'b0, 32'h0,         "data_wr22"};
    vecs[12] = '{1'b0, 4'h4, 32'h0,          1'b1, 32'h0002_0004, "stat_tx2"};
    vecs[13] = '{1'b0, 4'h5, 32'h0,          1'b1, 32'h0002_0004, "stat_alias"};

    do_reset();
    chk("irq_reset", {31'd0, irq}, 32'd0);
    chk("rx_ready_reset", {31'd0, uart_rx_ready}, 32'd1);

    for (int i = 0; i < 14; i++) begin
      bus_op(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd);
      if (vecs[i].chk) chk(vecs[i].name, rd, vecs[i].exp);
    end
    chk("tx_head_11", {24'd0, uart_tx_data}, 32'h11);
    chk("tx_valid_queued", {31'd0, uart_tx_valid}, 32'd1);

    // TX drain with ready toggling
    do_reset();
    bus_op(1'b1, 4'h0, 32'h41, rd);
    bus_op(1'b1, 4'h0, 32'h42, rd);
    bus_op(1'b1, 4'h0, 32'h43, rd);
    drain(3, 8'h41, 1'b1, "tx_drain");
    bus_op(1'b0, 4'h4, 32'h0, rd);
    chk("stat_tx_drained", rd, 32'h0000_0006);

    // TX overflow
    for (int i = 0; i < 9; i++) bus_op(1'b1, 4'h0, 32'h60 + i, rd);
    bus_op(1'b0, 4'h4, 32'h0, rd);
    chk("stat_tx_ovf", rd, 32'h0008_0025);
    chk("irq_tx_ovf", {31'd0, irq}, 32'd1);
    bus_op(1'b1, 4'hC, 32'h20, rd);
    bus_op(1'b0, 4'h4, 32'h0, rd);
    chk("stat_tx_ovf_clr", rd, 32'h0008_0005);
    drain(8, 8'h60, 1'b0, "tx_ovf_drain");

    // RX path
    inject(8'h5A);
    inject(8'hA5);
    bus_op(1'b0, 4'h0, 32'h0, rd);
    chk("rx_rd_5a", rd, 32'h5A);
    bus_op(1'b0, 4'h0, 32'h0, rd);
    chk("rx_rd_a5", rd, 32'hA5);
    bus_op(1'b0, 4'h0, 32'h0, rd);
    chk("rx_rd_empty", rd, 32'h0);
    for (int i = 0; i < 9; i++) begin
      inject(8'h80 + 8'(i));
      if (i == 7) chk("rx_ready_full", {31'd0, uart_rx_ready}, 32'd0);
    end
    bus_op(1'b0, 4'h4, 32'h0, rd);
    chk("stat_rx_ovf", rd, 32'h0000_081A);

    // Reset mid-traffic: RX full, ovf set, a TX byte parked with tx_en=0
    bus_op(1'b1, 4'h8, 32'h0, rd);
    bus_op(1'b1, 4'h0, 32'h5C, rd);
    chk("tx_head_5c", {24'd0, uart_tx_data}, 32'h5C);
    @(negedge clk);
    bus_req = 1'b1; bus_we = 1'b0; bus_addr = 4'h4;
    @(posedge clk);
    #1 rstn = 1'b0;
    bus_req = 1'b0;
    #1;
    chk("rst_ack", {31'd0, bus_ack}, 32'd0);
    chk("rst_rdata", bus_rdata, 32'd0);
    chk("rst_tx_valid", {31'd0, uart_tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, uart_tx_data}, 32'd0);
    chk("rst_rx_ready", {31'd0, uart_rx_ready}, 32'd1);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    bus_op(1'b0, 4'h4, 32'h0, rd);
    chk("rst_stat", rd, 32'h0000_0006);
    bus_op(1'b0, 4'h8, 32'h0, rd);
    chk("rst_ctrl", rd, 32'h0000_0001);

    // IRQ timing
    bus_op(1'b1, 4'h8, 32'h3, rd);
    inject(8'h3C);
    chk("irq_one_after_push", {31'd0, irq}, 32'd0);
    @(negedge clk);
    chk("irq_two_after_push", {31'd0, irq}, 32'd1);
    bus_op(1'b0, 4'h0, 32'h0, rd);
    chk("irq_rx_byte", rd, 32'h3C);
    @(negedge clk);
    chk("irq_after_pop", {31'd0, irq}, 32'd0);
    bus_op(1'b1, 4'h8, 32'h5, rd);
    @(negedge clk);
    chk("irq_tx_empty", {31'd0, irq}, 32'd1);

    // Full TX FIFO: write and pop in the same cycle
    do_reset();
    for (int i = 0; i < 8; i++) bus_op(1'b1, 4'h0, 32'h70 + i, rd);
    @(negedge clk);
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = 4'h0; bus_wdata = 32'h99;
    uart_tx_ready = 1'b1;
    @(negedge clk);
    bus_req = 1'b0; bus_we = 1'b0; uart_tx_ready = 1'b0;
    bus_op(1'b0, 4'h4, 32'h0, rd);
    chk("stat_full_wr_pop", rd, 32'h0007_0024);
    chk("tx_head_71", {24'd0, uart_tx_data}, 32'h71);
    bus_op(1'b1, 4'h8, 32'h0, rd);
    chk("tx_en_off_valid", {31'd0, uart_tx_valid}, 32'd0);
    bus_op(1'b0, 4'h4, 32'h0, rd);
    chk("stat_tx_en_off", rd, 32'h0007_0024);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
